// File: rtl/eth_udp_rx_parser.sv
// Purpose : Parses an Ethernet/IPv4/UDP receive byte stream and forwards only the UDP payload for port UDP_PORT.
// Latency : 1 cycle from input byte to payload byte; frame status pulses 1 cycle after the rxDataLast byte.
// Backpressure: none; at most one output byte per valid input byte, consumer must always accept.
//
// Ports:
//   rxClkLcl               - the only clock
//   rst                    - synchronous active-high reset
//   rxDataValid/Last/Data  - input byte stream; first valid byte is dst MAC byte 0, last byte is final FCS byte
//   payloadValid/Last/Data - forwarded UDP payload bytes; payloadLast on the final payload byte
//   payloadErr             - qualifies payloadLast: frame ended before the UDP length was satisfied
//   frameDone              - 1-cycle pulse, accepted frame ended
//   frameDrop              - 1-cycle pulse, frame rejected or truncated
//   fcsErr                 - 1-cycle pulse alongside frameDone when the FCS is bad
//
// Build option: define ETH_FCS_CHECK_EN to add the CRC-32 FCS checker; otherwise fcsErr is tied 0.

module eth_udp_rx_parser #(
    parameter logic [15:0] UDP_PORT    = 16'd5000,
    parameter logic [15:0] MAX_PAYLOAD = 16'd1472
) (
    input  logic       rxClkLcl,
    input  logic       rst,
    input  logic       rxDataValid,
    input  logic       rxDataLast,
    input  logic [7:0] rxData,
    output logic       payloadValid,
    output logic       payloadLast,
    output logic       payloadErr,
    output logic [7:0] payloadData,
    output logic       frameDone,
    output logic       frameDrop,
    output logic       fcsErr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_PAYLOAD,
        S_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;          // bytes received so far in this frame, saturating
    logic [15:0] etype_q, etype_d;
    logic [7:0]  verihl_q, verihl_d;
    logic [7:0]  proto_q, proto_d;
    logic [15:0] dport_q, dport_d;
    logic [15:0] udplen_q, udplen_d;
    logic [15:0] rem_q, rem_d;          // payload bytes still to forward
    logic        acc_q, acc_d;          // headers passed for the current frame

    logic        pvld_q, pvld_d;
    logic        plast_q, plast_d;
    logic        perr_q, perr_d;
    logic [7:0]  pdat_q, pdat_d;
    logic        done_q, done_d;
    logic        drop_q, drop_d;

    logic        hdr_ok;
    logic [10:0] cnt_inc;

    // Upper bound widened by one bit so MAX_PAYLOAD+8 cannot wrap.
    assign hdr_ok = (etype_q == 16'h0800) &&
                    (verihl_q == 8'h45) &&
                    (proto_q == 8'h11) &&
                    (dport_q == UDP_PORT) &&
                    (udplen_q >= 16'd8) &&
                    ({1'b0, udplen_q} <= ({1'b0, MAX_PAYLOAD} + 17'd8));

    assign cnt_inc = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        etype_d  = etype_q;
        verihl_d = verihl_q;
        proto_d  = proto_q;
        dport_d  = dport_q;
        udplen_d = udplen_q;
        rem_d    = rem_q;
        acc_d    = acc_q;
        pvld_d   = 1'b0;
        plast_d  = 1'b0;
        perr_d   = 1'b0;
        pdat_d   = 8'h00;
        done_d   = 1'b0;
        drop_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (rxDataValid) begin
                    acc_d = 1'b0;
                    if (rxDataLast) begin
                        // A one-byte frame can never carry a header.
                        drop_d = 1'b1;
                        cnt_d  = 11'd0;
                    end else begin
                        cnt_d   = 11'd1;
                        state_d = S_HDR;
                    end
                end
            end

            S_HDR: begin
                if (rxDataValid) begin
                    cnt_d = cnt_inc;
                    // cnt_q is the index of the byte currently on rxData.
                    case (cnt_q)
                        11'd12:  etype_d[15:8]  = rxData;
                        11'd13:  etype_d[7:0]   = rxData;
                        11'd14:  verihl_d       = rxData;
                        11'd23:  proto_d        = rxData;
                        11'd36:  dport_d[15:8]  = rxData;
                        11'd37:  dport_d[7:0]   = rxData;
                        11'd38:  udplen_d[15:8] = rxData;
                        11'd39:  udplen_d[7:0]  = rxData;
                        default: ;
                    endcase
                    if (rxDataLast) begin
                        drop_d  = 1'b1;
                        cnt_d   = 11'd0;
                        state_d = S_IDLE;
                    end else if (cnt_q == 11'd41) begin
                        // Byte 41 is the UDP checksum low byte; all checked fields are latched by now.
                        if (hdr_ok) begin
                            acc_d   = 1'b1;
                            rem_d   = udplen_q - 16'd8;
                            state_d = (udplen_q == 16'd8) ? S_DRAIN : S_PAYLOAD;
                        end else begin
                            acc_d   = 1'b0;
                            state_d = S_DRAIN;
                        end
                    end
                end
            end

            S_PAYLOAD: begin
                if (rxDataValid) begin
                    cnt_d  = cnt_inc;
                    pvld_d = 1'b1;
                    pdat_d = rxData;
                    rem_d  = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        plast_d = 1'b1;
                        if (rxDataLast) begin
                            done_d  = 1'b1;
                            cnt_d   = 11'd0;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DRAIN;
                        end
                    end else if (rxDataLast) begin
                        // Frame ended short of the UDP length: close the payload with an error.
                        plast_d = 1'b1;
                        perr_d  = 1'b1;
                        drop_d  = 1'b1;
                        acc_d   = 1'b0;
                        cnt_d   = 11'd0;
                        state_d = S_IDLE;
                    end
                end
            end

            S_DRAIN: begin
                if (rxDataValid) begin
                    cnt_d = cnt_inc;
                    if (rxDataLast) begin
                        done_d  = acc_q;
                        drop_d  = ~acc_q;
                        cnt_d   = 11'd0;
                        state_d = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge rxClkLcl) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 11'd0;
            etype_q  <= 16'h0000;
            verihl_q <= 8'h00;
            proto_q  <= 8'h00;
            dport_q  <= 16'h0000;
            udplen_q <= 16'h0000;
            rem_q    <= 16'h0000;
            acc_q    <= 1'b0;
            pvld_q   <= 1'b0;
            plast_q  <= 1'b0;
            perr_q   <= 1'b0;
            pdat_q   <= 8'h00;
            done_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            etype_q  <= etype_d;
            verihl_q <= verihl_d;
            proto_q  <= proto_d;
            dport_q  <= dport_d;
            udplen_q <= udplen_d;
            rem_q    <= rem_d;
            acc_q    <= acc_d;
            pvld_q   <= pvld_d;
            plast_q  <= plast_d;
            perr_q   <= perr_d;
            pdat_q   <= pdat_d;
            done_q   <= done_d;
            drop_q   <= drop_d;
        end
    end

    assign payloadValid = pvld_q;
    assign payloadLast  = plast_q;
    assign payloadErr   = perr_q;
    assign payloadData  = pdat_q;
    assign frameDone    = done_q;
    assign frameDrop    = drop_q;

`ifdef ETH_FCS_CHECK_EN
    // Reflected CRC-32 run over every byte including the FCS; a good frame leaves the fixed residue.
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    logic [31:0] crc_q, crc_d;
    logic [31:0] crc_seed, crc_next;
    logic        fcs_q, fcs_d;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc_in, input logic [7:0] b);
        logic [31:0] c;
        c = crc_in ^ {24'h000000, b};
        for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    always_comb begin
        crc_seed = (state_q == S_IDLE) ? CRC_INIT : crc_q;
        crc_next = crc_byte(crc_seed, rxData);
        crc_d    = rxDataValid ? crc_next : crc_q;
        fcs_d    = done_d && (crc_next != CRC_RESIDUE);
    end

    always_ff @(posedge rxClkLcl) begin
        if (rst) begin
            crc_q <= CRC_INIT;
            fcs_q <= 1'b0;
        end else begin
            crc_q <= crc_d;
            fcs_q <= fcs_d;
        end
    end

    assign fcsErr = fcs_q;
`else
    assign fcsErr = 1'b0;
`endif

endmodule

// File: tb/tb_eth_udp_rx_parser.sv
// Purpose : Directed self-checking bench for eth_udp_rx_parser.
// Latency : expects payload and status outputs one cycle after the input byte.
// Backpressure: none; the bench drives bytes freely.

module tb_eth_udp_rx_parser;

    logic       rxClkLcl = 1'b0;
    logic       rst = 1'b1;
    logic       rxDataValid = 1'b0;
    logic       rxDataLast = 1'b0;
    logic [7:0] rxData = 8'h00;
    logic       payloadValid, payloadLast, payloadErr, frameDone, frameDrop, fcsErr;
    logic [7:0] payloadData;

    eth_udp_rx_parser dut (
        .rxClkLcl     (rxClkLcl),
        .rst          (rst),
        .rxDataValid  (rxDataValid),
        .rxDataLast   (rxDataLast),
        .rxData       (rxData),
        .payloadValid (payloadValid),
        .payloadLast  (payloadLast),
        .payloadErr   (payloadErr),
        .payloadData  (payloadData),
        .frameDone    (frameDone),
        .frameDrop    (frameDrop),
        .fcsErr       (fcsErr)
    );

    always #5 rxClkLcl = ~rxClkLcl;

`ifdef ETH_FCS_CHECK_EN
    localparam logic [31:0] EXP_BAD_FCS = 32'd1;
`else
    localparam logic [31:0] EXP_BAD_FCS = 32'd0;
`endif

    int ncmp = 0;
    int nfail = 0;
    int cyc = 0;

    logic [7:0] fr [0:127];
    int         fr_len;

    logic [7:0] pq [$];
    int         n_last, n_err, n_done, n_drop, n_fcs;
    logic [7:0] last_byte;
    logic       last_err, done_fcs;
    int         done_cyc, drop_cyc, first_pv_cyc;
    int         drv_last_cyc, drv_p0_cyc;

    always @(posedge rxClkLcl) cyc <= cyc + 1;

    // Output collector, sampling away from the active edge.
    always @(negedge rxClkLcl) begin
        if (payloadValid) begin
            if (pq.size() == 0) first_pv_cyc = cyc;
            pq.push_back(payloadData);
            if (payloadLast) begin
                n_last++;
                last_byte = payloadData;
                last_err  = payloadErr;
            end
            if (payloadErr) n_err++;
        end
        if (frameDone) begin
            n_done++;
            done_cyc = cyc;
            done_fcs = fcsErr;
        end
        if (frameDrop) begin
            n_drop++;
            drop_cyc = cyc;
        end
        if (fcsErr) n_fcs++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        ncmp++;
        assert (obs === exp_v) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_mon();
        pq.delete();
        n_last = 0; n_err = 0; n_done = 0; n_drop = 0; n_fcs = 0;
        last_byte = 8'h00; last_err = 1'b0; done_fcs = 1'b0;
        done_cyc = -1; drop_cyc = -1; first_pv_cyc = -1;
        drv_last_cyc = -2; drv_p0_cyc = -2;
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'h0, b};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    // Builds a frame of tot bytes (FCS included) with npay payload bytes 0,1,2.. and a valid FCS.
    task automatic build(input logic [15:0] et, input logic [7:0] vi, input logic [7:0] pr,
                         input logic [15:0] dp, input logic [15:0] ul, input int npay, input int tot);
        logic [31:0] crc;
        for (int i = 0; i < 128; i++) fr[i] = 8'h00;
        for (int i = 0; i < 6; i++) fr[i] = 8'hFF;
        for (int i = 6; i < 12; i++) fr[i] = 8'(8'h10 + i);
        fr[12] = et[15:8]; fr[13] = et[7:0];
        fr[14] = vi;
        fr[23] = pr;
        fr[34] = 8'h13; fr[35] = 8'h88;
        fr[36] = dp[15:8]; fr[37] = dp[7:0];
        fr[38] = ul[15:8]; fr[39] = ul[7:0];
        for (int i = 0; i < npay; i++) fr[42 + i] = 8'(i);
        fr_len = tot;
        crc = 32'hFFFFFFFF;
        for (int i = 0; i < tot - 4; i++) crc = crc_upd(crc, fr[i]);
        crc = ~crc;
        fr[tot-4] = crc[7:0];   fr[tot-3] = crc[15:8];
        fr[tot-2] = crc[23:16]; fr[tot-1] = crc[31:24];
    endtask

    // Drives fr[0..fr_len-1]; one idle gap cycle before byte gap_at; idle==0 leaves the bus for a back-to-back frame.
    task automatic send(input int idle, input int gap_at);
        for (int i = 0; i < fr_len; i++) begin
            if (i == gap_at) begin
                @(posedge rxClkLcl); #1;
                rxDataValid = 1'b0; rxDataLast = 1'b0; rxData = 8'h5A;
            end
            @(posedge rxClkLcl); #1;
            rxDataValid = 1'b1;
            rxData      = fr[i];
            rxDataLast  = (i == fr_len - 1);
            if (i == fr_len - 1) drv_last_cyc = cyc;
            if (i == 42) drv_p0_cyc = cyc;
        end
        if (idle > 0) begin
            @(posedge rxClkLcl); #1;
            rxDataValid = 1'b0; rxDataLast = 1'b0; rxData = 8'h00;
            repeat (idle - 1) @(posedge rxClkLcl);
            #1;
        end
    endtask

    initial begin
        clear_mon();

        // Reset state
        repeat (3) @(posedge rxClkLcl);
        #1;
        chk("reset_outputs", {24'h0, payloadValid, payloadLast, payloadErr, frameDone,
                              frameDrop, fcsErr, 2'b00}, 32'h0);
        chk("reset_data", {24'h0, payloadData}, 32'h0);
        rst = 1'b0;
        repeat (2) @(posedge rxClkLcl);
        #1;

        // Good 64-byte frame, port 5000, udpLen 18, with an idle gap inside the payload
        build(16'h0800, 8'h45, 8'h11, 16'd5000, 16'd18, 10, 64);
        clear_mon();
        send(3, 45);
        chk("good_count", pq.size(), 10);
        for (int i = 0; i < 10; i++) chk("good_byte", {24'h0, pq[i]}, i);
        chk("good_nlast", n_last, 1);
        chk("good_lastbyte", {24'h0, last_byte}, 32'h09);
        chk("good_lasterr", {31'h0, last_err}, 0);
        chk("good_done", n_done, 1);
        chk("good_drop", n_drop, 0);
        chk("good_done_cyc", done_cyc, drv_last_cyc + 1);
        chk("good_latency", first_pv_cyc, drv_p0_cyc + 1);
        chk("good_fcs", n_fcs, 0);

        // Wrong destination port
        build(16'h0800, 8'h45, 8'h11, 16'd5001, 16'd18, 10, 64);
        clear_mon();
        send(3, -1);
        chk("port_count", pq.size(), 0);
        chk("port_drop", n_drop, 1);
        chk("port_drop_cyc", drop_cyc, drv_last_cyc + 1);
        chk("port_done", n_done, 0);

        // IPv6 EtherType
        build(16'h86DD, 8'h45, 8'h11, 16'd5000, 16'd18, 10, 64);
        clear_mon();
        send(3, -1);
        chk("etype_count", pq.size(), 0);
        chk("etype_drop", n_drop, 1);

        // IHL not 5
        build(16'h0800, 8'h46, 8'h11, 16'd5000, 16'd18, 10, 64);
        clear_mon();
        send(3, -1);
        chk("ihl_count", pq.size(), 0);
        chk("ihl_drop", n_drop, 1);

        // TCP protocol
        build(16'h0800, 8'h45, 8'h06, 16'd5000, 16'd18, 10, 64);
        clear_mon();
        send(3, -1);
        chk("proto_drop", n_drop, 1);

        // udpLen one above MAX_PAYLOAD+8
        build(16'h0800, 8'h45, 8'h11, 16'd5000, 16'd1481, 10, 64);
        clear_mon();
        send(3, -1);
        chk("lenmax_count", pq.size(), 0);
        chk("lenmax_drop", n_drop, 1);

        // udpLen below the UDP header size
        build(16'h0800, 8'h45, 8'h11, 16'd5000, 16'd7, 0, 64);
        clear_mon();
        send(3, -1);
        chk("lenmin_drop", n_drop, 1);

        // udpLen 8: accepted, empty payload
        build(16'h0800, 8'h45, 8'h11, 16'd5000, 16'd8, 0, 64);
        clear_mon();
        send(3, -1);
        chk("len8_count", pq.size(), 0);
        chk("len8_done", n_done, 1);
        chk("len8_drop", n_drop, 0);

        // udpLen 10 in a minimum padded frame: padding not forwarded
        build(16'h0800, 8'h45, 8'h11, 16'd5000, 16'd10, 2, 64);
        clear_mon();
        send(3, -1);
        chk("pad_count", pq.size(), 2);
        chk("pad_byte1", {24'h0, last_byte}, 32'h01);
        chk("pad_done", n_done, 1);
        chk("pad_done_cyc", done_cyc, drv_last_cyc + 1);

        // Truncated on the 5th of 10 payload bytes
        build(16'h0800, 8'h45, 8'h11, 16'd5000, 16'd18, 10, 64);
        fr_len = 47;
        clear_mon();
        send(3, -1);
        chk("trunc_count", pq.size(), 5);
        chk("trunc_lastbyte", {24'h0, last_byte}, 32'h04);
        chk("trunc_lasterr", {31'h0, last_err}, 1);
        chk("trunc_nerr", n_err, 1);
        chk("trunc_drop", n_drop, 1);
        chk("trunc_done", n_done, 0);
        chk("trunc_drop_cyc", drop_cyc, drv_last_cyc + 1);

        // Frame ends inside the header
        build(16'h0800, 8'h45, 8'h11, 16'd5000, 16'd18, 10, 64);
        fr_len = 30;
        clear_mon();
        send(3, -1);
        chk("hdrend_count", pq.size(), 0);
        chk("hdrend_drop", n_drop, 1);

        // Corrupted FCS: still frameDone; fcsErr only with the checker built in
        build(16'h0800, 8'h45, 8'h11, 16'd5000, 16'd18, 10, 64);
        fr[63] = fr[63] ^ 8'h01;
        clear_mon();
        send(3, -1);
        chk("badfcs_count", pq.size(), 10);
        chk("badfcs_done", n_done, 1);
        chk("badfcs_drop", n_drop, 0);
        chk("badfcs_n", n_fcs, EXP_BAD_FCS);
        chk("badfcs_with_done", {31'h0, done_fcs}, EXP_BAD_FCS);

        // Back-to-back good frames, no idle between them
        build(16'h0800, 8'h45, 8'h11, 16'd5000, 16'd18, 10, 64);
        clear_mon();
        send(0, -1);
        send(3, -1);
        chk("b2b_count", pq.size(), 20);
        chk("b2b_byte10", {24'h0, pq[10]}, 32'h00);
        chk("b2b_byte19", {24'h0, pq[19]}, 32'h09);
        chk("b2b_done", n_done, 2);
        chk("b2b_drop", n_drop, 0);
        chk("b2b_fcs", n_fcs, 0);

        // Reset in the middle of the payload
        clear_mon();
        for (int i = 0; i < 46; i++) begin
            @(posedge rxClkLcl); #1;
            rxDataValid = 1'b1; rxData = fr[i]; rxDataLast = 1'b0;
        end
        @(posedge rxClkLcl); #1;
        rst = 1'b1; rxDataValid = 1'b1; rxData = 8'hAA; rxDataLast = 1'b0;
        @(posedge rxClkLcl); #1;
        chk("rst_pre_count", pq.size(), 4);
        chk("rst_outputs", {24'h0, payloadValid, payloadLast, payloadErr, frameDone,
                            frameDrop, fcsErr, 2'b00}, 32'h0);
        chk("rst_data", {24'h0, payloadData}, 32'h0);
        rst = 1'b0; rxDataValid = 1'b0; rxData = 8'h00;
        repeat (2) @(posedge rxClkLcl);
        #1;
        clear_mon();
        send(3, -1);
        chk("post_rst_count", pq.size(), 10);
        chk("post_rst_byte0", {24'h0, pq[0]}, 32'h00);
        chk("post_rst_done", n_done, 1);
        chk("post_rst_drop", n_drop, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
